// File: rtl/register_file_mp.sv
// Multi-port general-purpose register file with write-to-read bypass and a
// per-register busy scoreboard for RAW hazard detection at issue.
module register_file_mp #(
   parameter int REG_NUM  = 32,
   parameter int REG_SIZE = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_RD*AW-1:0]         rd_addr,
   output logic [NUM_RD*REG_SIZE-1:0]   rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR*AW-1:0]         wr_addr,
   input  logic [NUM_WR*REG_SIZE-1:0]   wr_data,
   input  logic                         busy_set_en,
   input  logic [AW-1:0]                busy_set_addr,
   output logic [REG_NUM-1:0]           busy_vec
);

   logic [REG_SIZE-1:0] mem_r [REG_NUM];
   logic [REG_NUM-1:0]  busy_r;

   logic [NUM_WR-1:0]   wr_ok_s;
   logic [REG_NUM-1:0]  wr_hit_s;
   logic [REG_SIZE-1:0] wr_val_s [REG_NUM];
   logic                busy_set_ok_s;
   logic [REG_NUM-1:0]  busy_next_s;

   // True for addresses that hold real, writable state (in range, not the hardwired zero).
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (32'(a) < 32'(REG_NUM)) && !((ZERO_REG != 0) && (a == {AW{1'b0}}));
   endfunction

   // Qualify each write port against the address map.
   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         wr_ok_s[j] = wr_en[j] && addr_ok(wr_addr[j*AW +: AW]);
      end
   end

   // Per-register write resolution; later (higher-index) ports override earlier ones.
   always_comb begin
      for (int i = 0; i < REG_NUM; i++) begin
         wr_hit_s[i] = 1'b0;
         wr_val_s[i] = {REG_SIZE{1'b0}};
      end
      for (int j = 0; j < NUM_WR; j++) begin
         for (int i = 0; i < REG_NUM; i++) begin
            wr_val_s[i] = (wr_ok_s[j] && (wr_addr[j*AW +: AW] == AW'(i)))
                          ? wr_data[j*REG_SIZE +: REG_SIZE] : wr_val_s[i];
            wr_hit_s[i] = wr_hit_s[i] | (wr_ok_s[j] && (wr_addr[j*AW +: AW] == AW'(i)));
         end
      end
   end

   // Next scoreboard state: a same-cycle issue beats the clearing write.
   always_comb begin
      busy_set_ok_s = busy_set_en && addr_ok(busy_set_addr);
      for (int i = 0; i < REG_NUM; i++) begin
         busy_next_s[i] = (busy_set_ok_s && (busy_set_addr == AW'(i)))
                          | (busy_r[i] & ~wr_hit_s[i]);
      end
   end

   // Register array and scoreboard state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            mem_r[i] <= {REG_SIZE{1'b0}};
         end
         busy_r <= {REG_NUM{1'b0}};
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (wr_hit_s[i]) begin
               mem_r[i] <= wr_val_s[i];
            end else begin
               mem_r[i] <= mem_r[i];
            end
         end
         busy_r <= busy_next_s;
      end
   end

   // Combinational read ports: array lookup, then bypass from the in-flight writes.
   always_comb begin
      logic [AW-1:0] ra_v;
      logic          ok_v;
      rd_data = {(NUM_RD*REG_SIZE){1'b0}};
      rd_busy = {NUM_RD{1'b0}};
      ra_v    = {AW{1'b0}};
      ok_v    = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra_v = rd_addr[k*AW +: AW];
         ok_v = addr_ok(ra_v);
         for (int i = 0; i < REG_NUM; i++) begin
            rd_data[k*REG_SIZE +: REG_SIZE] = (ok_v && (ra_v == AW'(i)))
                                              ? mem_r[i] : rd_data[k*REG_SIZE +: REG_SIZE];
            rd_busy[k] = (ok_v && (ra_v == AW'(i))) ? busy_r[i] : rd_busy[k];
         end
         // Busy is deliberately not bypassed; only data is.
         for (int j = 0; j < NUM_WR; j++) begin
            rd_data[k*REG_SIZE +: REG_SIZE] =
               ((BYPASS != 0) && !rst && ok_v && wr_ok_s[j] && (wr_addr[j*AW +: AW] == ra_v))
               ? wr_data[j*REG_SIZE +: REG_SIZE] : rd_data[k*REG_SIZE +: REG_SIZE];
         end
      end
   end

   assign busy_vec = busy_r;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: three instances (default, no bypass,
// 24 registers) share one stimulus stream; expectations are queued per cycle.
module tb_register_file_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        busy_set_en;
   logic [4:0]  busy_set_addr;

   logic [63:0] rd_data_a, rd_data_b, rd_data_c;
   logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;
   logic [31:0] busy_vec_a, busy_vec_b;
   logic [23:0] busy_vec_c;

   always #5 clk = ~clk;

   register_file_mp #(.BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .busy_vec(busy_vec_a));

   register_file_mp #(.BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .busy_vec(busy_vec_b));

   register_file_mp #(.REG_NUM(24)) dut_c (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .busy_vec(busy_vec_c));

   typedef struct packed {
      logic [1:0]  dut;
      logic [1:0]  kind;   // 0 data, 1 rd_busy, 2 busy_vec
      logic        port;
      logic [31:0] val;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    tests_run    = 0;
   int    tests_failed = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] observe(input exp_t e);
      int          p;
      logic [31:0] r;
      p = int'(e.port);
      r = 32'h0;
      case (e.kind)
         2'd0: case (e.dut)
                  2'd0:    r = rd_data_a[p*32 +: 32];
                  2'd1:    r = rd_data_b[p*32 +: 32];
                  default: r = rd_data_c[p*32 +: 32];
               endcase
         2'd1: case (e.dut)
                  2'd0:    r = {31'b0, rd_busy_a[p]};
                  2'd1:    r = {31'b0, rd_busy_b[p]};
                  default: r = {31'b0, rd_busy_c[p]};
               endcase
         default: case (e.dut)
                  2'd0:    r = busy_vec_a;
                  2'd1:    r = busy_vec_b;
                  default: r = {8'b0, busy_vec_c};
               endcase
      endcase
      return r;
   endfunction

   // Queue one expectation per instance: va for dut_a, vb for dut_b, vc for dut_c.
   task automatic exp3(input string tag, input logic [1:0] kind, input logic port,
                       input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc);
      logic [31:0] v;
      for (int d = 0; d < 3; d++) begin
         v = (d == 0) ? va : ((d == 1) ? vb : vc);
         exp_q.push_back('{dut: 2'(d), kind: kind, port: port, val: v});
         tag_q.push_back($sformatf("%s/dut%0d/p%0d", tag, d, port));
      end
   endtask

   task automatic drive(input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic bse, input logic [4:0] bsa,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      wr_en         = wen;
      wr_addr       = {wa1, wa0};
      wr_data       = {wd1, wd0};
      busy_set_en   = bse;
      busy_set_addr = bsa;
      rd_addr       = {ra1, ra0};
   endtask

   // Let combinational outputs settle, drain the scoreboard, advance to next negedge.
   task automatic step;
      exp_t  e;
      string t;
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_eq(t, observe(e), e.val);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // All registers cleared after reset.
      for (int i = 0; i < 16; i++) begin
         drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(2*i), 5'(2*i+1));
         exp3($sformatf("rst_rd%0d", 2*i), 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
         exp3($sformatf("rst_rd%0d", 2*i+1), 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
         exp3($sformatf("rst_bsy%0d", 2*i), 2'd1, 1'b0, 32'h0, 32'h0, 32'h0);
         if (i == 0) exp3("rst_vec", 2'd2, 1'b0, 32'h0, 32'h0, 32'h0);
         step();
      end

      // Basic write, same-cycle bypass, then read-back.
      drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
      exp3("wr5_byp", 2'd0, 1'b0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
      exp3("rd5", 2'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      step();

      // Hardwired zero register.
      drive(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      exp3("z_wr", 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
      exp3("z_wr_bsy", 2'd1, 1'b0, 32'h0, 32'h0, 32'h0);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
         exp3("z_rd", 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
         exp3("z_bsy", 2'd1, 1'b0, 32'h0, 32'h0, 32'h0);
         exp3("z_vec", 2'd2, 1'b0, 32'h0, 32'h0, 32'h0);
         step();
      end

      // Dual-write conflict: port 1 wins, both for storage and bypass.
      drive(2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF, 1'b0, 5'd0, 5'd7, 5'd7);
      exp3("cf_byp0", 2'd0, 1'b0, 32'h5555FFFF, 32'h0, 32'h5555FFFF);
      exp3("cf_byp1", 2'd0, 1'b1, 32'h5555FFFF, 32'h0, 32'h5555FFFF);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
      exp3("cf_rd", 2'd0, 1'b0, 32'h5555FFFF, 32'h5555FFFF, 32'h5555FFFF);
      step();

      // Bypass on vs off.
      drive(2'b01, 5'd3, 32'h11, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      step();
      drive(2'b01, 5'd3, 32'h22, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
      exp3("nb_same", 2'd0, 1'b0, 32'h22, 32'h11, 32'h22);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
      exp3("nb_next", 2'd0, 1'b0, 32'h22, 32'h22, 32'h22);
      step();

      // Scoreboard set, clear, and set-beats-clear.
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
      exp3("sb_set_pre", 2'd1, 1'b0, 32'h0, 32'h0, 32'h0);
      step();
      drive(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
      exp3("sb_busy", 2'd1, 1'b0, 32'h1, 32'h1, 32'h1);
      exp3("sb_vec", 2'd2, 1'b0, 32'h200, 32'h200, 32'h200);
      exp3("sb_wr_byp", 2'd0, 1'b0, 32'h99, 32'h0, 32'h99);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
      exp3("sb_clr", 2'd1, 1'b0, 32'h0, 32'h0, 32'h0);
      exp3("sb_clr_vec", 2'd2, 1'b0, 32'h0, 32'h0, 32'h0);
      exp3("sb_clr_rd", 2'd0, 1'b0, 32'h99, 32'h99, 32'h99);
      step();
      drive(2'b10, 5'd0, 32'h0, 5'd9, 32'h77, 1'b1, 5'd9, 5'd0, 5'd9);
      exp3("sb_both_byp", 2'd0, 1'b1, 32'h77, 32'h99, 32'h77);
      exp3("sb_both_pre", 2'd1, 1'b1, 32'h0, 32'h0, 32'h0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
      exp3("sb_both_bsy", 2'd1, 1'b1, 32'h1, 32'h1, 32'h1);
      exp3("sb_both_vec", 2'd2, 1'b0, 32'h200, 32'h200, 32'h200);
      exp3("sb_both_rd", 2'd0, 1'b1, 32'h77, 32'h77, 32'h77);
      step();

      // Reset in the middle of activity overrides write and busy_set.
      drive(2'b01, 5'd4, 32'hCAFE, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
      exp3("mr_wr", 2'd0, 1'b0, 32'hCAFE, 32'h0, 32'hCAFE);
      step();
      rst = 1'b1;
      drive(2'b01, 5'd4, 32'hBEEF, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd9);
      exp3("mr_nobyp", 2'd0, 1'b0, 32'hCAFE, 32'hCAFE, 32'hCAFE);
      exp3("mr_bsy4", 2'd1, 1'b0, 32'h1, 32'h1, 32'h1);
      exp3("mr_rd9", 2'd0, 1'b1, 32'h77, 32'h77, 32'h77);
      exp3("mr_vec", 2'd2, 1'b0, 32'h210, 32'h210, 32'h210);
      step();
      rst = 1'b0;
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
      exp3("mr_rd4", 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
      exp3("mr_rd9z", 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
      exp3("mr_bsy", 2'd1, 1'b0, 32'h0, 32'h0, 32'h0);
      exp3("mr_vecz", 2'd2, 1'b0, 32'h0, 32'h0, 32'h0);
      step();

      // Out-of-range address 30 on the 24-entry instance.
      drive(2'b01, 5'd30, 32'hF00D, 5'd0, 32'h0, 1'b1, 5'd30, 5'd30, 5'd6);
      exp3("oor_byp", 2'd0, 1'b0, 32'hF00D, 32'h0, 32'h0);
      exp3("oor_alias", 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd30, 5'd6);
      exp3("oor_rd", 2'd0, 1'b0, 32'hF00D, 32'hF00D, 32'h0);
      exp3("oor_bsy", 2'd1, 1'b0, 32'h1, 32'h1, 32'h0);
      exp3("oor_vec", 2'd2, 1'b0, 32'h40000000, 32'h40000000, 32'h0);
      exp3("oor_alias_rd", 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
      step();

      // Last valid (23) and first invalid (24) address of the 24-entry instance.
      drive(2'b11, 5'd23, 32'h2323, 5'd24, 32'h2424, 1'b0, 5'd0, 5'd23, 5'd24);
      exp3("edge_byp23", 2'd0, 1'b0, 32'h2323, 32'h0, 32'h2323);
      exp3("edge_byp24", 2'd0, 1'b1, 32'h2424, 32'h0, 32'h0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd23, 5'd24);
      exp3("edge_rd23", 2'd0, 1'b0, 32'h2323, 32'h2323, 32'h2323);
      exp3("edge_rd24", 2'd0, 1'b1, 32'h2424, 32'h2424, 32'h0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
